// File: rtl/i2c_sram_target.sv
// i2c_sram_target
//
// Purpose
//   I2C target (slave) that fronts an internal byte-wide SRAM of MEM_DEPTH
//   words. It supports 1- or 2-byte word addressing, page-wrapped multi-byte
//   writes, sequential and current-address reads, repeated-START random reads
//   and master ACK/NACK handling on reads.
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   reset     in   asynchronous, active-high reset
//   A0/A1/A2  in   device-address strap pins (static)
//   SCL       in   raw bus clock from the pad
//   sda_in    in   raw SDA from the pad
//   sda_oe    out  1 = pull SDA low, 0 = release (open drain)
//   busy      out  high from own-address ACK until STOP / non-matching START
//   wr_pulse  out  one-cycle pulse per byte committed to the SRAM
//
// Configuration
//   I2C_SPIKE_FILTER_EN  when defined, a 3-sample majority filter follows the
//                        synchronisers on SCL and SDA (adds 2 clocks of event
//                        latency, rejects glitches of one clock or less).

module i2c_sram_target #(
  parameter logic [3:0] DEV_ADDR_HI = 4'b1010,
  parameter int         MEM_DEPTH   = 256,
  parameter int         ADDR_BYTES  = 1,
  parameter int         PAGE_SIZE   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic SCL,
  input  logic sda_in,
  output logic sda_oe,
  output logic busy,
  output logic wr_pulse
);

  localparam int            AW           = $clog2(MEM_DEPTH);
  localparam int            WAW          = 8 * ADDR_BYTES;
  localparam logic [AW-1:0] PAGE_MASK    = AW'(PAGE_SIZE - 1);
  localparam logic [1:0]    ADDR_CNT_END = 2'(ADDR_BYTES);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  // Synchronisers for the raw pad inputs. They reset to 1 so an idle bus
  // does not produce a spurious edge when reset is released.
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_f;
  logic sda_f;

`ifdef I2C_SPIKE_FILTER_EN
  // Majority vote over the current and two previous synchronised samples.
  // A pulse that lasts a single sample never wins the vote.
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_s};
      sda_hist <= {sda_hist[0], sda_s};
      scl_f    <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  // One-flop delay of the cleaned bus lines, used to find edges and
  // START/STOP conditions.
  logic scl_d;
  logic sda_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  // Registered protocol state and its next-state values.
  state_t         state,      state_nxt;
  logic [3:0]     bit_cnt,    bit_cnt_nxt;
  logic [6:0]     rx_shift,   rx_shift_nxt;
  logic [6:0]     tx_shift,   tx_shift_nxt;
  logic [WAW-2:0] addr_shift, addr_shift_nxt;
  logic [1:0]     addr_cnt,   addr_cnt_nxt;
  logic [AW-1:0]  ptr,        ptr_nxt;
  logic           rw,         rw_nxt;
  logic           rd_load,    rd_load_nxt;
  logic           sda_oe_nxt;
  logic           busy_nxt;
  logic           wr_pulse_nxt;

  logic [7:0]     rx_byte;
  logic [WAW-1:0] addr_word;
  logic [6:0]     own_addr;
  logic [AW-1:0]  ptr_page_inc;

  assign rx_byte      = {rx_shift, sda_f};
  assign addr_word    = {addr_shift, sda_f};
  assign own_addr     = {DEV_ADDR_HI, A2, A1, A0};
  assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + 1'b1) & PAGE_MASK);

  // SRAM port controls, produced by the FSM below.
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_q;
  logic [7:0] mem [MEM_DEPTH];

  // Byte-wide SRAM with a one-cycle synchronous read. Contents survive reset
  // on purpose, so there is no reset branch here.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[ptr] <= mem_wdata;
    end
    if (mem_re) begin
      mem_q <= mem[ptr];
    end
  end

  // State register for the protocol FSM and its datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      addr_shift <= '0;
      addr_cnt   <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      rd_load    <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_pulse   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      rx_shift   <= rx_shift_nxt;
      tx_shift   <= tx_shift_nxt;
      addr_shift <= addr_shift_nxt;
      addr_cnt   <= addr_cnt_nxt;
      ptr        <= ptr_nxt;
      rw         <= rw_nxt;
      rd_load    <= rd_load_nxt;
      sda_oe     <= sda_oe_nxt;
      busy       <= busy_nxt;
      wr_pulse   <= wr_pulse_nxt;
    end
  end

  // Next-state and output logic. START/STOP override any bit handling in
  // the same cycle. In the ACK states sda_oe doubles as the phase marker:
  // the first SCL fall asserts it, the second one ends the ACK slot.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    rx_shift_nxt   = rx_shift;
    tx_shift_nxt   = tx_shift;
    addr_shift_nxt = addr_shift;
    addr_cnt_nxt   = addr_cnt;
    ptr_nxt        = ptr;
    rw_nxt         = rw;
    rd_load_nxt    = rd_load;
    sda_oe_nxt     = sda_oe;
    busy_nxt       = busy;
    wr_pulse_nxt   = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_wdata      = rx_byte;

    if (stop_det) begin
      state_nxt   = ST_IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      rd_load_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_DEV;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      rd_load_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_IGNORE: begin
        end

        ST_DEV: begin
          if (scl_rise) begin
            rx_shift_nxt = rx_byte[6:0];
            bit_cnt_nxt  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              if (rx_byte[7:1] == own_addr) begin
                state_nxt = ST_DEV_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = ST_IGNORE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end

        ST_DEV_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              if (rw) begin
                state_nxt   = ST_RDATA;
                mem_re      = 1'b1;
                rd_load_nxt = 1'b1;
              end else begin
                state_nxt    = ST_WADDR;
                addr_cnt_nxt = '0;
              end
            end
          end
        end

        ST_WADDR: begin
          if (scl_rise) begin
            addr_shift_nxt = addr_word[WAW-2:0];
            bit_cnt_nxt    = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt  = '0;
              addr_cnt_nxt = addr_cnt + 2'd1;
              state_nxt    = ST_WADDR_ACK;
              if (addr_cnt + 2'd1 == ADDR_CNT_END) begin
                ptr_nxt = AW'(addr_word);
              end
            end
          end
        end

        ST_WADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = (addr_cnt == ADDR_CNT_END) ? ST_WDATA : ST_WADDR;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            rx_shift_nxt = rx_byte[6:0];
            bit_cnt_nxt  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt  = '0;
              mem_we       = 1'b1;
              wr_pulse_nxt = 1'b1;
              ptr_nxt      = ptr_page_inc;
              state_nxt    = ST_WDATA_ACK;
            end
          end
        end

        ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (rd_load) begin
            rd_load_nxt  = 1'b0;
            tx_shift_nxt = mem_q[6:0];
            sda_oe_nxt   = ~mem_q[7];
            bit_cnt_nxt  = '0;
          end else if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              ptr_nxt     = ptr + 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = ST_RACK;
            end else begin
              sda_oe_nxt   = ~tx_shift[6];
              tx_shift_nxt = {tx_shift[5:0], 1'b0};
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nxt   = ST_RDATA;
            mem_re      = 1'b1;
            rd_load_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_sram_target.sv
// tb_i2c_sram_target
//
// Purpose
//   Bit-banged I2C master driving i2c_sram_target, with a byte-array model
//   of the SRAM and word pointer used to predict every read and ACK.
//
// Ports
//   none (top-level bench)

`timescale 1ns/1ps

module tb_i2c_sram_target;

  localparam int PAGE = 16;
  localparam int DEPTH = 256;

  logic clock = 1'b0;
  logic reset;
  logic A0 = 1'b0;
  logic A1 = 1'b0;
  logic A2 = 1'b0;
  logic SCL;
  logic sda_m;
  logic sda_bus;
  logic sda_oe;
  logic busy;
  logic wr_pulse;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  logic [7:0] model_mem [DEPTH];
  bit         model_valid [DEPTH];
  int         model_ptr;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = sda_m & ~sda_oe;

  i2c_sram_target dut (
    .clock    (clock),
    .reset    (reset),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .SCL      (SCL),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse)
  );

  always #5 clock = ~clock;

  // Count committed bytes as seen on wr_pulse.
  always @(posedge clock) begin
    if (wr_pulse === 1'b1) wr_count++;
  end

  // Safety net so a broken design can never hang the run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic scl_v, input logic sda_v, input int n);
    SCL   = scl_v;
    sda_m = sda_v;
    waitClocks(n);
  endtask

  task automatic i2cStart();
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 6);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b1, 12);
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, b, 6);
    applyStimulus(1'b1, b, 12);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 6);
    b = sda_bus;
    waitClocks(6);
  endtask

  task automatic writeByte(input logic [7:0] data, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(b);
    ack = ~b;
  endtask

  // Reads one byte, then drives ACK (send_ack=1) or NACK; also reports
  // whether the target was pulling SDA during that ACK slot.
  task automatic readByte(input logic send_ack, output logic [7:0] data, output logic oe_in_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      data[i] = b;
    end
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, ~send_ack, 6);
    applyStimulus(1'b1, ~send_ack, 6);
    oe_in_ack = sda_oe;
    waitClocks(6);
  endtask

  // Reference behaviour: writes wrap inside the page, pointer ends after
  // the last written byte.
  task automatic modelWrite(input logic [7:0] addr, input logic [7:0] data [$]);
    int p;
    p = int'(addr);
    foreach (data[i]) begin
      model_mem[p]   = data[i];
      model_valid[p] = 1'b1;
      p = (p / PAGE) * PAGE + ((p + 1) % PAGE);
    end
    model_ptr = p;
  endtask

  task automatic memWrite(input logic [7:0] addr, input logic [7:0] data [$], output logic all_ack);
    logic a;
    all_ack = 1'b1;
    i2cStart();
    writeByte(8'hA0, a); all_ack &= a;
    writeByte(addr, a);  all_ack &= a;
    foreach (data[i]) begin
      writeByte(data[i], a);
      all_ack &= a;
    end
    i2cStop();
    modelWrite(addr, data);
  endtask

  // Random read: set the pointer with a dummy write, repeated START, then
  // read n bytes, ACKing all but the last.
  task automatic randomRead(input logic [7:0] addr, input int n, output logic [7:0] got [$], output logic all_ack);
    logic a;
    logic oe;
    logic [7:0] d;
    got = {};
    all_ack = 1'b1;
    i2cStart();
    writeByte(8'hA0, a); all_ack &= a;
    writeByte(addr, a);  all_ack &= a;
    i2cStart();
    writeByte(8'hA1, a); all_ack &= a;
    for (int i = 0; i < n; i++) begin
      readByte(i != n - 1, d, oe);
      got.push_back(d);
    end
    i2cStop();
    model_ptr = (int'(addr) + n) % DEPTH;
  endtask

  task automatic checkRead(input string tag, input int addr, input logic [7:0] got [$]);
    int p;
    foreach (got[i]) begin
      p = (addr + i) % DEPTH;
      if (model_valid[p]) checkOutput(tag, got[i], model_mem[p]);
    end
  endtask

  initial begin
    logic       ok;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       oe;
    logic       b;
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] q [$];
    logic [7:0] got [$];
    int         wr_before;
    int         addr;
    int         len;
    int         oe_seen;

    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    model_ptr = 0;

    reset = 1'b1;
    SCL   = 1'b1;
    sda_m = 1'b1;
    waitClocks(5);
    checkOutput("reset sda_oe", sda_oe, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wr_pulse", wr_pulse, 0);
    reset = 1'b0;
    waitClocks(5);

    // Fill page 0 with random data so later reads have known contents.
    q = {};
    for (int i = 0; i < PAGE; i++) q.push_back(8'($urandom_range(0, 255)));
    wr_before = wr_count;
    memWrite(8'h00, q, ok);
    checkOutput("preload acks", ok, 1);
    checkOutput("preload writes", wr_count - wr_before, PAGE);

    // Single byte write 0x3C to address 5.
    wr_before = wr_count;
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h05, a1);
    writeByte(8'h3C, a2);
    checkOutput("byte write dev ack", a0, 1);
    checkOutput("byte write addr ack", a1, 1);
    checkOutput("byte write data ack", a2, 1);
    checkOutput("busy during write", busy, 1);
    i2cStop();
    checkOutput("busy after stop", busy, 0);
    checkOutput("byte write pulses", wr_count - wr_before, 1);
    q = {8'h3C};
    modelWrite(8'h05, q);

    // Random read of address 5, NACK, SDA released during RACK.
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h05, a1);
    i2cStart();
    writeByte(8'hA1, a2);
    readByte(1'b0, d, oe);
    i2cStop();
    checkOutput("random read acks", {a0, a1, a2}, 3'b111);
    checkOutput("random read data", d, 8'h3C);
    checkOutput("sda_oe in rack", oe, 0);
    model_ptr = 6;

    // Current-address read proves the pointer moved to 6.
    i2cStart();
    writeByte(8'hA1, a0);
    readByte(1'b0, d, oe);
    i2cStop();
    checkOutput("current read ack", a0, 1);
    checkOutput("current read data", d, model_mem[model_ptr]);
    model_ptr = (model_ptr + 1) % DEPTH;

    // Page wrap: 0x0E, 0x0F, then back to 0x00.
    q = {8'h11, 8'h22, 8'h33};
    wr_before = wr_count;
    memWrite(8'h0E, q, ok);
    checkOutput("page wrap acks", ok, 1);
    checkOutput("page wrap pulses", wr_count - wr_before, 3);
    randomRead(8'h0E, 2, got, ok);
    checkOutput("page wrap read 0E", got[0], 8'h11);
    checkOutput("page wrap read 0F", got[1], 8'h22);
    randomRead(8'h00, 1, got, ok);
    checkOutput("page wrap read 00", got[0], 8'h33);

    // Sequential read across the end of the array.
    r = 8'($urandom_range(0, 255));
    q = {r};
    memWrite(8'hFF, q, ok);
    randomRead(8'hFF, 2, got, ok);
    checkOutput("seq wrap acks", ok, 1);
    checkOutput("seq wrap read FF", got[0], r);
    checkOutput("seq wrap read 00", got[1], 8'h33);

    // Wrong device address: no ACK, no write, not busy.
    wr_before = wr_count;
    i2cStart();
    writeByte(8'hA2, a0);
    writeByte(8'h77, a1);
    checkOutput("mismatch dev ack", a0, 0);
    checkOutput("mismatch data ack", a1, 0);
    checkOutput("mismatch busy", busy, 0);
    i2cStop();
    checkOutput("mismatch pulses", wr_count - wr_before, 0);

    // Partial byte: STOP after 4 data bits leaves pointer at the address.
    r = 8'($urandom_range(0, 255));
    q = {r};
    memWrite(8'h30, q, ok);
    wr_before = wr_count;
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h30, a1);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    writeBit(1'b0);
    i2cStop();
    checkOutput("partial pulses", wr_count - wr_before, 0);
    model_ptr = 8'h30;
    i2cStart();
    writeByte(8'hA1, a0);
    readByte(1'b0, d, oe);
    i2cStop();
    checkOutput("partial pointer read", d, r);
    model_ptr = (model_ptr + 1) % DEPTH;

    // Randomised write/read-back transfers.
    for (int t = 0; t < 6; t++) begin
      addr = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
      wr_before = wr_count;
      memWrite(8'(addr), q, ok);
      checkOutput("rand write acks", ok, 1);
      checkOutput("rand write pulses", wr_count - wr_before, len);
      randomRead(8'(addr), len, got, ok);
      checkOutput("rand read acks", ok, 1);
      checkRead("rand read data", addr, got);
    end

    // Reset in the middle of a read byte, while the target drives SDA low.
    q = {8'h00};
    memWrite(8'h50, q, ok);
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h50, a1);
    i2cStart();
    writeByte(8'hA1, a2);
    readBit(b);
    readBit(b);
    readBit(b);
    applyStimulus(1'b0, sda_m, 6);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("read drive before reset", sda_oe, 1);
    reset = 1'b1;
    #1;
    checkOutput("reset mid-read sda_oe", sda_oe, 0);
    checkOutput("reset mid-read busy", busy, 0);
    waitClocks(3);
    reset = 1'b0;
    model_ptr = 0;
    oe_seen = 0;
    for (int i = 0; i < 4; i++) begin
      readBit(b);
      if (sda_oe !== 1'b0) oe_seen++;
    end
    checkOutput("idle after reset", oe_seen, 0);
    i2cStart();
    writeByte(8'hA1, a0);
    readByte(1'b0, d, oe);
    i2cStop();
    checkOutput("post-reset read ack", a0, 1);
    checkOutput("post-reset read data", d, model_mem[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_sram_target.md
# i2c_sram_target

Parametrised I2C target (slave) fronting an internal byte-wide SRAM of `MEM_DEPTH` words, the next generation of the team's single-address I2C memory slave. Adds 1- or 2-byte word addressing, page-wrapped multi-byte writes, sequential and current-address reads, repeated-START random reads, and full master ACK/NACK handling. Sits on the board-level I2C bus; SDA is open-drain through an external pad cell driven by `sda_oe`.

## Interface
- `DEV_ADDR_HI`, 4'b1010: upper 4 bits of the 7-bit device address; lower 3 bits come from `A2..A0`.
- `MEM_DEPTH`, 256: SRAM words; power of two, 16..65536. `AW = $clog2(MEM_DEPTH)`.
- `ADDR_BYTES`, 1: word-address bytes per transfer, 1 or 2; must satisfy `8*ADDR_BYTES >= AW`.
- `PAGE_SIZE`, 16: write-wrap page in bytes; power of two, <= `MEM_DEPTH`.
- `SYNC_STAGES`, 2: synchroniser flops on SCL/SDA, >= 2.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `A0`, `A1`, `A2`  in  1 each  device-address strap pins; static.
- `SCL`  in  1  bus clock (raw pad input).
- `sda_in`  in  1  SDA pad input (raw).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. Reset 0.
- `busy`  out  1  1 from own-address ACK until STOP or non-matching START. Reset 0.
- `wr_pulse`  out  1  one-cycle pulse per byte committed to SRAM. Reset 0.

## Operation
- SCL/SDA pass through `SYNC_STAGES` flops, then a 1-flop edge detector. START = SDA fall while SCL high; STOP = SDA rise while SCL high. START/STOP take priority over any bit processing in the same cycle.
- Bits sampled on SCL rise, MSB first. `sda_oe` changes only on the cycle after SCL fall.
- States: IDLE, DEV (8 bits incl. R/W), DEV_ACK, WADDR (8*`ADDR_BYTES` bits, ACK after each byte), WDATA, WDATA_ACK, RDATA, RACK (sample master ACK/NACK), IGNORE.
- IDLE -> DEV on START. START from any state -> DEV (repeated START). STOP from any state -> IDLE, `sda_oe`=0, `busy`=0.
- DEV: on 8th bit, address match -> DEV_ACK; mismatch -> IGNORE (no ACK) until START/STOP.
- DEV_ACK: `sda_oe`=1 from SCL fall after bit 8 to the next SCL fall. Then: R/W=0 -> WADDR; R/W=1 -> RDATA from the current pointer (current-address / random read).
- WADDR: each byte ACKed. After the last byte, pointer <= received address mod `MEM_DEPTH` (bits above AW ignored) -> WDATA.
- WDATA: byte shifted in; on 8th SCL rise write SRAM[pointer], pulse `wr_pulse`, -> WDATA_ACK (ACK). Pointer low `log2(PAGE_SIZE)` bits increment with wrap; upper bits fixed. Unlimited bytes per transfer.
- Partial byte (STOP/START before bit 8): discarded, no write, pointer unchanged.
- RDATA: SRAM[pointer] loaded into TX shifter; each bit driven as `sda_oe = ~bit`. After 8 bits, pointer increments mod `MEM_DEPTH` (full-array wrap) -> RACK, `sda_oe`=0.
- RACK: SDA low at SCL rise (ACK) -> RDATA, next byte; high (NACK) -> IGNORE until STOP/START.
- Pointer persists across transfers; reset to 0 only by `reset`. SRAM contents are not cleared by reset.
- `reset` mid-transfer: immediate IDLE, `sda_oe`=0, `busy`=0, `wr_pulse`=0, pointer 0; subsequent bus activity ignored until next START.

## Timing
- Bus-event latency: `SYNC_STAGES`+1 clocks from pad edge to internal event.
- `clock` must be >= 16x SCL frequency; tHD;DAT = `SYNC_STAGES`+2 clocks after SCL fall at pad.
- SRAM read: 1-cycle synchronous read, issued on the SCL-fall cycle ending DEV_ACK/RACK; shifter loaded next cycle; first bit on `sda_oe` 2 clocks after internal SCL fall.
- SRAM write: on the cycle of the 8th internal SCL rise; `wr_pulse` high that cycle only.

## Configuration
- `I2C_SPIKE_FILTER_EN`: defined -> 3-sample majority filter on synchronised SCL and SDA, rejecting glitches <= 1 clock; event latency becomes `SYNC_STAGES`+3. Undefined -> no filter, latency `SYNC_STAGES`+1. Protocol behaviour otherwise identical.

## Test plan
- Byte write: A=000, START, 0xA0, 0x05, 0x3C, STOP -> three ACKs, `wr_pulse` once, SRAM[5]=0x3C, `busy` 0 after STOP.
- Random read: START, 0xA0, 0x05, Sr, 0xA1, read with NACK -> returns 0x3C, pointer=6, `sda_oe` released during RACK.
- Page wrap: PAGE_SIZE=16, write 0xA0, 0x0E, bytes 11,22,33 -> SRAM[0x0E]=11, [0x0F]=22, [0x00]=33.
- Sequential read wrap: pointer=0xFF (MEM_DEPTH=256), read 2 bytes with ACK then NACK -> SRAM[0xFF] then SRAM[0x00].
- Address mismatch/partial byte: 0xA2 with A=000 -> no ACK, no SRAM change; STOP after 4 data bits -> no write, pointer unchanged.
- Reset mid-read: assert `reset` while driving bit 3 of a read byte -> `sda_oe`=0 same cycle, state IDLE, next START/0xA1 reads SRAM[0].
